// File: rtl/note_seq_pkg.sv
// note_seq_pkg: note codes, step entry layout, FSM states and default melody
package note_seq_pkg;
   typedef logic [1:0] note_t;
   localparam note_t NOTE_FS5 = 2'd0;
   localparam note_t NOTE_A5  = 2'd1;
   localparam note_t NOTE_CS6 = 2'd2;
   localparam note_t NOTE_E6  = 2'd3;
   typedef struct packed {
      logic       rest;
      note_t      note;
      logic [2:0] beats_m1;
   } step_t;
   typedef enum logic [1:0] {ST_IDLE, ST_PLAY, ST_GAP} state_e;
   function automatic step_t mk_step(logic rest, note_t note, int beats);
      return '{rest: rest, note: note, beats_m1: 3'(beats - 1)};
   endfunction
   // entry 0 sits in the least significant slot
   localparam step_t [7:0] DEFAULT_PATTERN = {
      mk_step(1'b0, NOTE_FS5, 2),
      mk_step(1'b0, NOTE_A5,  1),
      mk_step(1'b1, NOTE_FS5, 1),
      mk_step(1'b0, NOTE_CS6, 2),
      mk_step(1'b0, NOTE_E6,  1),
      mk_step(1'b0, NOTE_CS6, 1),
      mk_step(1'b0, NOTE_A5,  1),
      mk_step(1'b0, NOTE_FS5, 1)
   };
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control and note/gate bus between a controller and the sequencer
interface note_sequencer_if;
   import note_seq_pkg::*;
   logic       START;
   logic       STOP;
   logic       LOOP;
   note_t      NOTE_SEL;
   logic       GATE;
   logic       BUSY;
   logic [3:0] STEP;
   logic       DONE;
   modport master (output START, STOP, LOOP, input NOTE_SEL, GATE, BUSY, STEP, DONE);
   modport slave  (input START, STOP, LOOP, output NOTE_SEL, GATE, BUSY, STEP, DONE);
endinterface

// File: rtl/note_sequencer_beat_timer.sv
// beat_timer: tick/beat counters for one step, flagging gap start and step end
module beat_timer #(
   parameter int TICKS_PER_BEAT = 2500,
   parameter int GAP_TICKS      = 250
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       restart,
   input  logic       en,
   input  logic [2:0] beats_m1,
   output logic       gap_start,
   output logic       step_end
);
   localparam int TW = $clog2(TICKS_PER_BEAT);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BEAT - 1);
   localparam logic [TW-1:0] TICK_GAP  = TW'(TICKS_PER_BEAT - 1 - GAP_TICKS);
   logic [TW-1:0] tick;
   logic [2:0]    beat;
   logic          last_beat;
   assign last_beat = beat == beats_m1;
   assign step_end  = en && last_beat && tick == TICK_LAST;
   assign gap_start = en && last_beat && tick == TICK_GAP;
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         tick <= '0;
         beat <= '0;
      end else if (restart) begin
         tick <= '0;
         beat <= '0;
      end else if (en) begin
         tick <= tick == TICK_LAST ? '0 : tick + 1'b1;
         beat <= tick == TICK_LAST ? beat + 1'b1 : beat;
      end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: steps through a note pattern, driving note select and gate to the oscillator
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int TICKS_PER_BEAT = 2500,
   parameter int GAP_TICKS      = 250,
   parameter int PATTERN_LEN    = 8,
   parameter step_t [PATTERN_LEN-1:0] PATTERN = DEFAULT_PATTERN
) (
   input logic CLK,
   input logic RST_N,
   note_sequencer_if.slave bus
);
   localparam logic [1:0] S_IDLE = ST_IDLE;
   localparam logic [1:0] S_PLAY = ST_PLAY;
   localparam logic [1:0] S_GAP  = ST_GAP;
   logic [1:0] state;
   logic [3:0] step, nxt_idx;
   note_t      note_sel, nxt_note;
   logic       gate, busy, done;
   logic       cur_rest, nxt_rest;
   logic [2:0] cur_beats;
   logic       idle, last, load, gap_start, step_end;
   assign idle    = state == S_IDLE;
   assign last    = step == 4'(PATTERN_LEN - 1);
   assign nxt_idx = (idle || last) ? '0 : step + 4'd1;
   always_comb begin
      cur_rest  = 1'b0;
      cur_beats = '0;
      nxt_rest  = 1'b0;
      nxt_note  = NOTE_FS5;
      for (int k = 0; k < PATTERN_LEN; k++) begin
         cur_rest  = step == 4'(k) ? PATTERN[k].rest : cur_rest;
         cur_beats = step == 4'(k) ? PATTERN[k].beats_m1 : cur_beats;
         nxt_rest  = nxt_idx == 4'(k) ? PATTERN[k].rest : nxt_rest;
         nxt_note  = nxt_idx == 4'(k) ? PATTERN[k].note : nxt_note;
      end
   end
   // a step loads on START from idle, or at step end unless the pattern finishes
   assign load = (idle && bus.START) || (step_end && !(last && !bus.LOOP));
   beat_timer #(
      .TICKS_PER_BEAT(TICKS_PER_BEAT),
      .GAP_TICKS     (GAP_TICKS)
   ) u_timer (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .restart  (idle || step_end),
      .en       (!idle),
      .beats_m1 (cur_beats),
      .gap_start(gap_start),
      .step_end (step_end)
   );
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         state    <= S_IDLE;
         step     <= '0;
         note_sel <= NOTE_FS5;
         gate     <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (bus.STOP) begin
            state <= S_IDLE;
            gate  <= 1'b0;
            busy  <= 1'b0;
         end else if (load) begin
            state    <= S_PLAY;
            busy     <= 1'b1;
            step     <= nxt_idx;
            gate     <= !nxt_rest;
            note_sel <= nxt_rest ? note_sel : nxt_note;
         end else if (step_end) begin
            state <= S_IDLE;
            gate  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
         end else if (gap_start && !cur_rest) begin
            state <= S_GAP;
            gate  <= 1'b0;
         end
      end
   assign bus.NOTE_SEL = note_sel;
   assign bus.GATE     = gate;
   assign bus.BUSY     = busy;
   assign bus.STEP     = step;
   assign bus.DONE     = done;
endmodule
